// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
//   Single-cycle fwd/add/and/or/sll/sr/ror; iterative shift-add multiply
//   that takes WIDTH cycles plus one cycle to publish the product.
//   Flags are registered together with the result, so they always match it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and select are valid this cycle
//   in_ready   block can accept an operation this cycle
//   data1      operand A / value to shift
//   data2      operand B / shift amount [SHAMT_W-1:0] / sr mode bit [WIDTH-1]
//   select     000 fwd, 001 add, 010 and, 011 or, 100 mul, 101 sll, 110 sr, 111 ror
//   out_valid  result and flags valid
//   out_ready  consumer takes the result this cycle
//   result     result (mul: low half of the product)
//   prod_hi    mul: high half of the unsigned product, otherwise 0
//   zero/neg   derived from result
//   carry      add: carry-out; mul: prod_hi != 0; otherwise 0
//   ovf        add: signed overflow; otherwise 0
module seq_alu #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prod_hi,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  // Counter is one bit wider than the shift amount so it can hold WIDTH.
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SR  = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     result_r;
  logic [WIDTH-1:0]     prod_hi_r;
  logic                 zero_r;
  logic                 neg_r;
  logic                 carry_r;
  logic                 ovf_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic [SHAMT_W-1:0]   shamt_s;
  logic [CNT_W-1:0]     rot_left_s;
  logic [WIDTH:0]       sum_s;
  logic signed [WIDTH-1:0] data1_sgn_s;
  logic [WIDTH-1:0]     sra_s;
  logic [WIDTH-1:0]     ror_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_carry_s;
  logic                 alu_ovf_s;
  logic [2*WIDTH-1:0]   acc_step_s;

  assign shamt_s     = data2[SHAMT_W-1:0];
  // Left part of the rotate; a shift by WIDTH yields 0, so amount 0 passes data1.
  assign rot_left_s  = WIDTH_C - {1'b0, shamt_s};
  assign sum_s       = {1'b0, data1} + {1'b0, data2};
  assign data1_sgn_s = data1;
  assign sra_s       = data1_sgn_s >>> shamt_s;
  assign ror_s       = (data1 >> shamt_s) | (data1 << rot_left_s);
  assign acc_step_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign accept_s    = in_valid & in_ready_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign prod_hi   = prod_hi_r;
  assign zero      = zero_r;
  assign neg       = neg_r;
  assign carry     = carry_r;
  assign ovf       = ovf_r;

  // Ready: always in IDLE, in HOLD only when the held result is being taken.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_HOLD: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Single-cycle datapath for every op except multiply.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (select)
      OP_FWD: alu_res_s = data2;
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (data1[WIDTH-1] == data2[WIDTH-1]) &
                      (sum_s[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND: alu_res_s = data1 & data2;
      OP_OR:  alu_res_s = data1 | data2;
      OP_SLL: alu_res_s = data1 << shamt_s;
      OP_SR: begin
        if (data2[WIDTH-1]) begin
          alu_res_s = sra_s;
        end else begin
          alu_res_s = data1 >> shamt_s;
        end
      end
      OP_ROR: alu_res_s = ror_s;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM, operand capture, shift-add multiply iterations and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      prod_hi_r   <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      acc_r       <= {(2*WIDTH){1'b0}};
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_HOLD: begin
          if (accept_s) begin
            if (select == OP_MUL) begin
              state_r     <= ST_MUL;
              out_valid_r <= 1'b0;
              acc_r       <= {(2*WIDTH){1'b0}};
              mcand_r     <= {{WIDTH{1'b0}}, data1};
              mplier_r    <= data2;
              cnt_r       <= {CNT_W{1'b0}};
            end else begin
              state_r     <= ST_HOLD;
              out_valid_r <= 1'b1;
              result_r    <= alu_res_s;
              prod_hi_r   <= {WIDTH{1'b0}};
              zero_r      <= (alu_res_s == {WIDTH{1'b0}});
              neg_r       <= alu_res_s[WIDTH-1];
              carry_r     <= alu_carry_s;
              ovf_r       <= alu_ovf_s;
            end
          end else if ((state_r == ST_HOLD) && out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_MUL: begin
          // All WIDTH partial products are in; publish on the following edge.
          if (cnt_r == WIDTH_C) begin
            state_r     <= ST_HOLD;
            out_valid_r <= 1'b1;
            result_r    <= acc_r[WIDTH-1:0];
            prod_hi_r   <= acc_r[2*WIDTH-1:WIDTH];
            zero_r      <= (acc_r[WIDTH-1:0] == {WIDTH{1'b0}});
            neg_r       <= acc_r[WIDTH-1];
            carry_r     <= (acc_r[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            ovf_r       <= 1'b0;
          end else begin
            acc_r    <= acc_step_s;
            mcand_r  <= mcand_r << 1'b1;
            mplier_r <= mplier_r >> 1'b1;
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus a randomized
// phase, all checked against a behavioural model and an in-order scoreboard.
module tb_seq_alu;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SR  = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] select;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] prod_hi;
  logic       zero;
  logic       neg;
  logic       carry;
  logic       ovf;

  logic [19:0] out_vec;
  logic [19:0] sb_q[$];
  logic        last_acc = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  assign out_vec = {result, prod_hi, zero, neg, carry, ovf};

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .select(select), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .prod_hi(prod_hi),
    .zero(zero), .neg(neg), .carry(carry), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {result, prod_hi, zero, neg, carry, ovf} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, amt, r, hi, c, v, p;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    amt = ub % 8;
    r = 0; hi = 0; c = 0; v = 0; p = 0;
    case (sel)
      OP_FWD: r = ub;
      OP_ADD: begin
        p = ua + ub;
        r = p % 256;
        c = (p > 255) ? 1 : 0;
        v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
      end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_MUL: begin
        p = ua * ub;
        r = p % 256;
        hi = p / 256;
        c = (hi != 0) ? 1 : 0;
      end
      OP_SLL: r = (ua << amt) % 256;
      OP_SR:  r = (ub >= 128) ? ((sa >>> amt) & 255) : (ua >> amt);
      OP_ROR: r = ((ua >> amt) | (ua << (8 - amt))) & 255;
      default: r = 0;
    endcase
    model = {r[7:0], hi[7:0], (r == 0), (r >= 128), c[0], v[0]};
  endfunction

  // Scoreboard: compare deliveries in order, record accepts (sampled mid-cycle).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        last_acc = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            chk("sb", 32'(out_vec), 32'(sb_q.pop_front()));
          end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) sb_q.push_back(model(select, data1, data2));
      end
    end
  end

  // Present an op and return one step after the edge that accepted it.
  task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    int w;
    select = s; data1 = a; data2 = b; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("accept_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Count cycles from accept until out_valid, noting any in_ready while busy.
  task automatic mul_wait(output int n, output int bad);
    n = 0; bad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, bad, c0;
    logic [19:0] e_and;
    logic [7:0] oa, ob, a, b;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    select = 3'd0; data1 = 8'd0; data2 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'(out_vec), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Add: overflow and carry corners
    issue(OP_ADD, 8'h7F, 8'h01);
    in_valid = 1'b0;
    chk("add7f_valid", 32'(out_valid), 32'd1);
    chk("add7f_vec", 32'(out_vec), 32'({8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1}));
    issue(OP_ADD, 8'hFF, 8'h01);
    in_valid = 1'b0;
    chk("addff_vec", 32'(out_vec), 32'({8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}));

    // Multiply latency and results
    issue(OP_MUL, 8'hFF, 8'hFF);
    in_valid = 1'b0;
    mul_wait(n, bad);
    chk("mul_latency", 32'(n), 32'd9);
    chk("mul_busy_ready", 32'(bad), 32'd0);
    chk("mulff_vec", 32'(out_vec), 32'({8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0}));
    issue(OP_MUL, 8'h0F, 8'h11);
    in_valid = 1'b0;
    mul_wait(n, bad);
    chk("mul0f_latency", 32'(n), 32'd9);
    chk("mul0f_vec", 32'(out_vec), 32'({8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Shifts and rotate
    issue(OP_SR, 8'h80, 8'h82);
    chk("sr_arith", 32'(result), 32'hE0);
    issue(OP_SR, 8'h80, 8'h02);
    chk("sr_logic", 32'(result), 32'h20);
    issue(OP_ROR, 8'h81, 8'h01);
    chk("ror", 32'(result), 32'hC0);
    issue(OP_SLL, 8'h01, 8'h07);
    chk("sll_res", 32'(result), 32'h80);
    chk("sll_neg", 32'(neg), 32'd1);
    idle_cycle();

    // Backpressure with a queued OR handed over in the same cycle
    a = 8'($urandom); b = 8'($urandom);
    oa = 8'($urandom); ob = 8'($urandom);
    e_and = model(OP_AND, a, b);
    out_ready = 1'b0;
    issue(OP_AND, a, b);
    select = OP_OR; data1 = oa; data2 = ob; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", 32'(out_vec), 32'(e_and));
      chk("bp_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_handover_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_or_valid", 32'(out_valid), 32'd1);
    chk("bp_or_vec", 32'(out_vec), 32'(model(OP_OR, oa, ob)));

    // Streaming: 10 adds on 10 consecutive cycles
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      issue(OP_ADD, a, b);
      chk("stream_vec", 32'({out_valid, out_vec}), 32'({1'b1, model(OP_ADD, a, b)}));
    end
    in_valid = 1'b0;
    chk("stream_cycles", 32'(cyc - c0), 32'd10);

    // Reset in the middle of a multiply
    issue(OP_MUL, 8'h5A, 8'hC3);
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outs", 32'(out_vec), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(OP_ADD, 8'h02, 8'h03);
    in_valid = 1'b0;
    chk("post_rst_add", 32'(result), 32'h05);

    // Randomized traffic with random backpressure; scoreboard does the checking
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        select = 3'($urandom_range(0, 7));
        data1 = 8'($urandom);
        data2 = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
